muldiv_iter: RTL and testbench
==============================

Name: muldiv_iter

Overview:
Iterative RV32M multiply/divide unit that is the multi-cycle companion to the single-cycle ALU. It is parametrised in operand width and executes all eight M-extension operations selected by funct3 over a start/ready/done handshake. The core stalls while busy is high. A kill input aborts the in-flight operation on a pipeline flush.

Parameters:
WIDTH, 32, operand/result width in bits; must be even and >= 4.
CNTW, $clog2(WIDTH), iteration counter width (derived; do not override).

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only when ready=1.
kill  input  1  abort in-flight op; highest priority after reset.
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
a  input  WIDTH  rs1 operand (multiplicand / dividend).
b  input  WIDTH  rs2 operand (multiplier / divisor).
ready  output  1  can accept start this cycle.
busy  output  1  operation in CALC.
done  output  1  one-cycle pulse; result valid this cycle.
result  output  WIDTH  registered result; holds until next completion.

Behaviour:
- States: IDLE, CALC, DONE.
- ready = (state==IDLE)|(state==DONE). busy = (state==CALC). done = (state==DONE).
- Reset (reset_n=0, async): state=IDLE, counter=0, result=0, all internal operand/accumulator registers = 0. Outputs after reset: ready=1, busy=0, done=0.
- Accept: start&ready at edge E latches funct3, sign flags, and absolute values.
  - Signedness: a is signed for MULH, MULHSU, DIV, REM. b is signed for MULH, DIV, REM. All other operands are unsigned.
  - Normal path: state becomes CALC with counter=WIDTH-1.
- Special cases, detected at accept:
  - Divide with b==0: quotient = all ones; remainder = a.
  - Signed overflow, DIV/REM with a==MIN and b==-1: quotient = MIN; remainder = 0.
  - Both go straight to DONE, so done is high in the cycle after E.
- CALC, one iteration per cycle, WIDTH cycles total; counter decrements and CALC ends after counter==0.
  - Multiply: radix-2 shift-add on unsigned magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract on magnitudes, producing quotient and remainder.
- Final sign correction is applied when result is loaded, on the CALC->DONE transition.
  - Multiply: negate the 2*WIDTH product if the signs differ. MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
  - DIV: quotient negated if sign(a)^sign(b).
  - REM: remainder takes the sign of a.
  - DIVU/REMU: no correction.
- Latency: start accepted at edge E; done is high in the cycle beginning at edge E+WIDTH+1. Special cases complete at E+1.
- DONE lasts exactly one cycle.
  - start in DONE is accepted: the next op begins with the same timing as from IDLE, and done is still high for the finished op that cycle.
  - Otherwise DONE goes to IDLE.
- start when ready=0 is ignored; the bench must not rely on it being queued.
- Operand inputs are don't-care except at the accept edge.
- kill=1 at an edge while in CALC or DONE: state goes to IDLE, no done pulse, result unchanged.
  - kill takes precedence over start in the same cycle. A simultaneous start is dropped.
- Reset mid-operation: immediate return to IDLE with the reset values above; no done pulse.
- All arithmetic is modulo 2^WIDTH, or 2^(2*WIDTH) for the product. No exceptions or flags are raised.

Test Plan:
1. MUL, a=7, b=0xFFFFFFFD (-3), WIDTH=32 -> done exactly 33 cycles after the accept edge, result=0xFFFFFFEB. busy is high for exactly 32 cycles and ready is low throughout.
2. High-half multiplies:
   - MULH 0x80000000 x 0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. Division:
   - DIV -7/2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF.
   - DIVU 100/7 -> 14; REMU 100,7 -> 2.
   - REM 7,-2 -> 1.
4. Special cases, each with done one cycle after accept and busy never asserted:
   - DIV 5/0 -> 0xFFFFFFFF; REMU 5,0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
5. Abort:
   - kill at the 10th CALC cycle -> no done, ready=1 the next cycle, result keeps its prior value.
   - Separately, reset_n pulsed low mid-CALC -> result=0 and ready=1 immediately, with no clock edge needed.
6. Back-to-back and overlap:
   - MULU-style MULHU completes, and start for DIVU 9/3 is asserted in its DONE cycle -> second done 33 cycles later with result=3.
   - start pulses while busy=1 -> ignored; exactly one done per accepted op.
   - Parametrisation: rerun scenarios 1 and 3 with WIDTH=8 (e.g. DIV 0xF9/0x02 -> 0xFD) with latency 9.

Source files
------------

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M multiply/divide unit.
// One shift-add or shift-subtract step per cycle; signs fixed at completion.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNTW-1:0]  CNT_INIT = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic                 nega_q, nega_d;
  logic [WIDTH-1:0]     opd_q, opd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     result_q, result_d;

  // operand conditioning at accept
  logic             a_sgn, b_sgn;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             is_div, div0, ovf;
  logic [WIDTH-1:0] spec_res;

  // one iteration step and final sign correction
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rtmp, diff;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, iter;
  logic [2*WIDTH-1:0] prod_n;
  logic [WIDTH-1:0]   quo, rem, fin;

  assign ready  = (state_q == IDLE) | (state_q == DONE);
  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;

  // decode signedness, magnitudes and the early-exit divide cases
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (funct3)
      F_MULH:   begin a_sgn = a[WIDTH-1]; b_sgn = b[WIDTH-1]; end
      F_MULHSU: a_sgn = a[WIDTH-1];
      F_DIV:    begin a_sgn = a[WIDTH-1]; b_sgn = b[WIDTH-1]; end
      F_REM:    begin a_sgn = a[WIDTH-1]; b_sgn = b[WIDTH-1]; end
      default:  ;
    endcase
    a_abs  = a_sgn ? (~a + 1'b1) : a;
    b_abs  = b_sgn ? (~b + 1'b1) : b;
    is_div = funct3[2];
    div0   = is_div & (b == '0);
    ovf    = is_div & ~funct3[0] & (a == MIN_V) & (b == '1);
    spec_res = '0;
    unique case (1'b1)
      div0:    spec_res = funct3[1] ? a : '1;
      ovf:     spec_res = funct3[1] ? '0 : MIN_V;
      default: ;
    endcase
  end

  // single radix-2 step for both multiply and restoring divide
  always_comb begin
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
    mul_nxt = acc_q[0] ? {sum, acc_q[WIDTH-1:1]}
                       : {1'b0, acc_q[2*WIDTH-1:1]};
    rtmp    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = rtmp - {1'b0, opd_q};
    div_nxt = diff[WIDTH]
            ? {rtmp[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
            : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    iter    = op_q[2] ? div_nxt : mul_nxt;
  end

  // sign-correct the final step into the architectural result
  always_comb begin
    prod_n = neg_q ? (~iter + 1'b1) : iter;
    quo    = iter[WIDTH-1:0];
    rem    = iter[2*WIDTH-1:WIDTH];
    fin    = '0;
    unique case (op_q)
      F_MUL:    fin = prod_n[WIDTH-1:0];
      F_MULH:   fin = prod_n[2*WIDTH-1:WIDTH];
      F_MULHSU: fin = prod_n[2*WIDTH-1:WIDTH];
      F_MULHU:  fin = prod_n[2*WIDTH-1:WIDTH];
      F_DIV:    fin = neg_q ? (~quo + 1'b1) : quo;
      F_DIVU:   fin = quo;
      F_REM:    fin = nega_q ? (~rem + 1'b1) : rem;
      F_REMU:   fin = rem;
      default:  fin = '0;
    endcase
  end

  // next-state: kill, accept, iterate, complete
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    nega_d   = nega_q;
    opd_d    = opd_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (kill) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            op_d   = funct3;
            neg_d  = a_sgn ^ b_sgn;
            nega_d = a_sgn;
            opd_d  = is_div ? b_abs : a_abs;
            acc_d  = {{WIDTH{1'b0}}, (is_div ? a_abs : b_abs)};
            cnt_d  = CNT_INIT;
            if (div0 | ovf) begin
              state_d  = DONE;
              result_d = spec_res;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          acc_d = iter;
          if (cnt_q == '0) begin
            state_d  = DONE;
            result_d = fin;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      nega_q   <= 1'b0;
      opd_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      nega_q   <= nega_d;
      opd_q    <= opd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed checks for muldiv_iter
// at WIDTH=32 and WIDTH=8.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        s32 = 1'b0, k32 = 1'b0;
  logic [2:0]  f32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        rdy32, bsy32, dn32;
  logic [31:0] res32;

  logic        s8 = 1'b0, k8 = 1'b0;
  logic [2:0]  f8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        rdy8, bsy8, dn8;
  logic [7:0]  res8;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.WIDTH(32)) u32 (
    .clk(clk), .reset_n(reset_n), .start(s32), .kill(k32),
    .funct3(f32), .a(a32), .b(b32),
    .ready(rdy32), .busy(bsy32), .done(dn32), .result(res32)
  );

  muldiv_iter #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .start(s8), .kill(k8),
    .funct3(f8), .a(a8), .b(b8),
    .ready(rdy8), .busy(bsy8), .done(dn8), .result(res8)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // caller is at a negedge; returns at the negedge of the done cycle
  task automatic op32(input string tag, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat);
    int n, nb, bad;
    logic got;
    f32 = f; a32 = a; b32 = b; s32 = 1'b1;
    @(posedge clk);
    #1 s32 = 1'b0;
    n = 0; nb = 0; bad = 0; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      n++;
      if (bsy32) nb++;
      if (bsy32 && rdy32) bad++;
      if (dn32) got = 1'b1;
    end
    chk({tag, " lat"}, n, lat);
    chk({tag, " busy"}, nb, lat - 1);
    chk({tag, " rdy"}, bad, 0);
    chk({tag, " res"}, res32, exp);
  endtask

  task automatic op8(input string tag, input logic [2:0] f,
                     input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp, input int lat);
    int n;
    logic got;
    f8 = f; a8 = a; b8 = b; s8 = 1'b1;
    @(posedge clk);
    #1 s8 = 1'b0;
    n = 0; got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      n++;
      if (dn8) got = 1'b1;
    end
    chk({tag, " lat"}, n, lat);
    chk({tag, " res"}, {24'h0, res8}, {24'h0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int nd, nb;
    #12;
    chk("rst rdy", rdy32, 1'b1);
    chk("rst busy", bsy32, 1'b0);
    chk("rst done", dn32, 1'b0);
    chk("rst res", res32, 32'h0);
    chk("rst res8", {24'h0, res8}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    op32("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    op32("mulh", 3'b001, 32'h80000000, 32'h80000000,
         32'h40000000, 33);
    op32("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF,
         32'hFFFFFFFE, 33);
    op32("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF,
         32'hFFFFFFFF, 33);
    op32("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    op32("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    op32("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    op32("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    op32("rem+-", 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
    op32("div0", 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    op32("remu0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
    op32("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF,
         32'h80000000, 1);
    op32("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF,
         32'h0, 1);

    // start in DONE of MULHU begins DIVU with full latency
    op32("b2b mulhu", 3'b011, 32'hFFFFFFFF, 32'h2,
         32'h1, 33);
    op32("b2b divu", 3'b101, 32'd9, 32'd3, 32'd3, 33);

    // kill in the 10th CALC cycle
    f32 = 3'b000; a32 = 32'd3; b32 = 32'd5; s32 = 1'b1;
    @(posedge clk);
    #1 s32 = 1'b0;
    nb = 0;
    for (int i = 0; i < 40 && nb < 10; i++) begin
      @(negedge clk);
      if (bsy32) nb++;
    end
    chk("kill reach", nb, 10);
    k32 = 1'b1;
    @(posedge clk);
    #1 k32 = 1'b0;
    @(negedge clk);
    chk("kill rdy", rdy32, 1'b1);
    chk("kill busy", bsy32, 1'b0);
    chk("kill res", res32, 32'd3);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dn32) nd++;
    end
    chk("kill nodone", nd, 0);
    chk("kill res2", res32, 32'd3);

    // start pulses while busy are ignored
    f32 = 3'b101; a32 = 32'd100; b32 = 32'd7; s32 = 1'b1;
    @(posedge clk);
    #1 s32 = 1'b0;
    nd = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (dn32) nd++;
      if (i >= 3 && i <= 20) begin
        s32 = 1'b1; f32 = 3'b000; a32 = 32'd1; b32 = 32'd1;
      end else begin
        s32 = 1'b0;
      end
    end
    chk("ovl ndone", nd, 1);
    chk("ovl res", res32, 32'd14);

    // async reset mid-CALC
    f32 = 3'b000; a32 = 32'd9; b32 = 32'd9; s32 = 1'b1;
    @(posedge clk);
    #1 s32 = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst res", res32, 32'h0);
    chk("arst rdy", rdy32, 1'b1);
    chk("arst busy", bsy32, 1'b0);
    chk("arst done", dn32, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // WIDTH=8 reruns
    op8("w8 mul", 3'b000, 8'd7, 8'hFD, 8'hEB, 9);
    op8("w8 div", 3'b100, 8'hF9, 8'h02, 8'hFD, 9);
    op8("w8 rem", 3'b110, 8'hF9, 8'h02, 8'hFF, 9);
    op8("w8 divu", 3'b101, 8'd100, 8'd7, 8'd14, 9);
    op8("w8 remu", 3'b111, 8'd100, 8'd7, 8'd2, 9);
    op8("w8 rem+-", 3'b110, 8'd7, 8'hFE, 8'd1, 9);
    op8("w8 mulhu", 3'b011, 8'hFF, 8'hFF, 8'hFE, 9);
    op8("w8 div0", 3'b100, 8'd5, 8'd0, 8'hFF, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
